// File: rtl/ahb_irq_pulser.sv
// -----------------------------------------------------------------------------
// ahb_irq_pulser
//
// AHB slave interrupt controller feeding the 32-bit HIRQ input of the PicoRV
// AHB master. Peripheral interrupt levels are edge-detected, latched into
// PENDING, gated by MASK and turned into one-cycle pulses on HIRQ, so the
// processor never has to send an end-of-interrupt. Software reads PENDING and
// clears it with write-one-to-clear over a zero-wait-state register interface.
//
// Register map (word offset HADDR[3:2]):
//   0 PENDING  RO, write 1 clears the bit
//   1 MASK     RW, 1 = line enabled
//   2 FORCE    WO, write 1 sets the PENDING bit, reads 0
//   3 ID       RO, 32'h5049_5251
//
// Handshake: an address phase is accepted when HSEL & HTRANS[1] & HREADY.
// The data phase is the following cycle. Word transfers (HSIZE=3'b010) finish
// with zero wait states and OKAY. Any other size gets a two-cycle ERROR
// response (HREADYOUT low then high, HRESP=ERROR in both cycles) and has no
// side effects.
//
// Parameters:
//   NIRQ        number of interrupt lines (1..32); upper bits read 0
//   RESET_MASK  MASK value after reset
//
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA,
//   HREADY                AHB slave inputs
//   HREADYOUT, HRESP,
//   HRDATA                AHB slave outputs
//   IRQ_IN                peripheral interrupt levels
//   HIRQ                  one-cycle interrupt pulses
//   o_dbg_state           error-response FSM state, for observation only
//
// Build option:
//   IRQ_PULSER_SYNC_EN    when defined, IRQ_IN passes through a 2-flop
//                         synchronizer before edge detection (2 cycles extra
//                         latency). When undefined IRQ_IN must be synchronous
//                         to HCLK.
// -----------------------------------------------------------------------------
module ahb_irq_pulser #(
  parameter int          NIRQ       = 32,
  parameter logic [31:0] RESET_MASK = 32'h0000_0000
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic [1:0]      HRESP,
  output logic [31:0]     HRDATA,
  input  logic [NIRQ-1:0] IRQ_IN,
  output logic [31:0]     HIRQ,
  output logic [1:0]      o_dbg_state
);

  localparam logic [31:0] ID_VALUE  = 32'h5049_5251;
  // Bits that correspond to real interrupt lines.
  localparam logic [31:0] LINE_MASK = (NIRQ >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << NIRQ) - 32'd1);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_FORCE   = 2'd2;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t      r_state;

  // Data-phase registers captured from the address phase.
  logic        r_dp_valid;
  logic        r_dp_legal;
  logic        r_dp_write;
  logic [1:0]  r_dp_addr;

  logic [31:0] r_pend;
  logic [31:0] r_mask;
  logic [31:0] r_prev;
  // Low for the first clock after reset: that edge only loads r_prev.
  logic        r_armed;

  logic        w_capture;
  logic        w_legal;
  logic        w_dp_wr;
  logic [31:0] w_irq_raw;
  logic [31:0] w_irq;
  logic [31:0] w_rise;
  logic [31:0] w_clr;
  logic [31:0] w_force;
  logic        w_mask_wr;
  logic [31:0] w_pend_next;
  logic [31:0] w_mask_next;
  logic [31:0] w_fire;

  // Address bits outside [3:2] and HTRANS[0] do not affect decoding.
  logic        w_unused;
  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

  // ---------------------------------------------------------------------------
  // Interrupt input conditioning
  // ---------------------------------------------------------------------------
  generate
    if (NIRQ < 32) begin : g_irq_pad
      assign w_irq_raw = {{(32 - NIRQ){1'b0}}, IRQ_IN};
    end else begin : g_irq_full
      assign w_irq_raw = IRQ_IN;
    end
  endgenerate

`ifdef IRQ_PULSER_SYNC_EN
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_irq_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = w_irq_raw;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_capture = HSEL & HTRANS[1] & HREADY;
  assign w_legal   = (HSIZE == 3'b010);

  // A legal write data phase; commits at the clock edge that ends it.
  assign w_dp_wr   = r_dp_valid & r_dp_legal & r_dp_write;

  assign w_clr     = (w_dp_wr && (r_dp_addr == ADDR_PENDING)) ? (HWDATA & LINE_MASK) : '0;
  assign w_force   = (w_dp_wr && (r_dp_addr == ADDR_FORCE))   ? (HWDATA & LINE_MASK) : '0;
  assign w_mask_wr = w_dp_wr && (r_dp_addr == ADDR_MASK);

  // ---------------------------------------------------------------------------
  // Pending / mask / pulse
  // ---------------------------------------------------------------------------
  assign w_rise      = r_armed ? (w_irq & ~r_prev) : '0;

  // Set sources (edge or FORCE) are ORed in after the clear so they win.
  assign w_pend_next = ((r_pend & ~w_clr) | w_rise | w_force) & LINE_MASK;
  assign w_mask_next = w_mask_wr ? (HWDATA & LINE_MASK) : r_mask;

  // Pulse only on the transition of (pending & enabled) from 0 to 1.
  assign w_fire      = w_pend_next & w_mask_next & ~(r_pend & r_mask);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend  <= '0;
      r_mask  <= RESET_MASK & LINE_MASK;
      r_prev  <= '0;
      r_armed <= 1'b0;
      HIRQ    <= '0;
    end else begin
      r_pend  <= w_pend_next;
      r_mask  <= w_mask_next;
      r_prev  <= w_irq;
      r_armed <= 1'b1;
      HIRQ    <= w_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_legal <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else begin
      r_dp_valid <= w_capture;
      if (w_capture) begin
        r_dp_legal <= w_legal;
        r_dp_write <= HWRITE;
        r_dp_addr  <= HADDR[3:2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error-response FSM with registered HREADYOUT / HRESP.
  // ERR1 is the data phase of the illegal transfer (wait state), ERR2 its
  // completing cycle. A new address phase seen in ERR2 is accepted normally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
    end else begin
      case (r_state)
        S_ERR1: begin
          r_state   <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_ERROR;
        end
        default: begin
          if (w_capture && !w_legal) begin
            r_state   <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= RESP_ERROR;
          end else begin
            r_state   <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Read data: combinational from the registered address, so a read right
  // after a write to the same register sees the committed value.
  // ---------------------------------------------------------------------------
  always_comb begin
    HRDATA = '0;
    if (r_dp_valid && r_dp_legal && !r_dp_write) begin
      case (r_dp_addr)
        ADDR_PENDING: HRDATA = r_pend;
        ADDR_MASK:    HRDATA = r_mask;
        ADDR_FORCE:   HRDATA = '0;
        default:      HRDATA = ID_VALUE;
      endcase
    end
  end

endmodule
